// File: rtl/gy_offset_cal_pkg.sv
// Shared gyro package: calibration FSM states and default sizing.
package gy_offset_cal_pkg;

  typedef enum logic [1:0] {
    CAL   = 2'd0,
    LATCH = 2'd1,
    RUN   = 2'd2
  } gy_state_e;

  localparam int unsigned GY_N_LOG2   = 8;
  localparam int unsigned GY_DEADBAND = 4;
  localparam int unsigned GY_ACC_W    = 24;

endpackage

// File: rtl/gy_byte_assembler.sv
// Pairs a gyro Y high byte with the following low byte into a 16-bit raw sample.
module gy_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_first,
  output logic [15:0] raw,
  output logic        raw_valid
);

  logic [7:0] hi_q, hi_d;
  logic       pend_q, pend_d;

  // Hold the latest high byte; a low byte completes a sample only if one is pending.
  always_comb begin
    hi_d      = hi_q;
    pend_d    = pend_q;
    raw       = {hi_q, byte_in};
    raw_valid = 1'b0;
    if (clear) begin
      pend_d = 1'b0;
    end else if (byte_valid) begin
      if (byte_first) begin
        hi_d   = byte_in;
        pend_d = 1'b1;
      end else if (pend_q) begin
        raw_valid = 1'b1;
        pend_d    = 1'b0;
      end
    end
  end

  // Pending-byte registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/gy_offset_cal.sv
// Gyro Y offset calibration: averages 2^N_LOG2 samples, then streams
// offset-corrected, saturated, deadbanded samples.
module gy_offset_cal
  import gy_offset_cal_pkg::*;
#(
  parameter int unsigned N_LOG2   = GY_N_LOG2,
  parameter int unsigned DEADBAND = GY_DEADBAND
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_first,
  input  logic        recal,
  output logic [15:0] GY,
  output logic        is_read,
  output logic        cal_done,
  output logic [15:0] offset
);

  localparam logic signed [16:0] DB_POS = 17'(DEADBAND);
  localparam logic signed [16:0] DB_NEG = -DB_POS;

  gy_state_e                    state_q, state_d;
  logic signed [GY_ACC_W-1:0]   acc_q, acc_d;
  logic [N_LOG2-1:0]            cnt_q, cnt_d;
  logic [15:0]                  offset_q, offset_d;
  logic [15:0]                  gy_q, gy_d;
  logic                         is_read_q, is_read_d;
  logic [15:0]                  raw_q, raw_d;
  logic                         raw_v_q, raw_v_d;

  logic [15:0]                  asm_raw;
  logic                         asm_valid;
  logic signed [16:0]           diff;
  logic [15:0]                  sat;
  logic [15:0]                  corr;

  gy_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (recal),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_first (byte_first),
    .raw        (asm_raw),
    .raw_valid  (asm_valid)
  );

  // Correction datapath: 17-bit difference, clamp to 16 bits, then deadband.
  always_comb begin
    diff = $signed({raw_q[15], raw_q}) - $signed({offset_q[15], offset_q});
    if (diff[16] != diff[15]) begin
      sat = diff[16] ? 16'h8000 : 16'h7fff;
    end else begin
      sat = diff[15:0];
    end
    if (diff > DB_NEG && diff < DB_POS) begin
      corr = '0;
    end else begin
      corr = sat;
    end
  end

  // Next-state: sample capture stage, calibration FSM, output stage.
  // recal squashes both the captured sample and the output stage so an
  // in-flight sample never produces is_read.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    offset_d  = offset_q;
    gy_d      = gy_q;
    is_read_d = 1'b0;
    raw_d     = asm_valid ? asm_raw : raw_q;
    raw_v_d   = asm_valid;
    if (recal) begin
      state_d = CAL;
      acc_d   = '0;
      cnt_d   = '0;
      raw_v_d = 1'b0;
    end else begin
      unique case (state_q)
        CAL: begin
          if (raw_v_q) begin
            acc_d = acc_q + GY_ACC_W'($signed(raw_q));
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
              state_d = LATCH;
            end
          end
        end
        LATCH: begin
          offset_d = 16'(acc_q >>> N_LOG2);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
        RUN: begin
          if (raw_v_q) begin
            gy_d      = corr;
            is_read_d = 1'b1;
          end
        end
        default: state_d = CAL;
      endcase
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CAL;
      acc_q     <= '0;
      cnt_q     <= '0;
      offset_q  <= '0;
      gy_q      <= '0;
      is_read_q <= 1'b0;
      raw_q     <= '0;
      raw_v_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      offset_q  <= offset_d;
      gy_q      <= gy_d;
      is_read_q <= is_read_d;
      raw_q     <= raw_d;
      raw_v_q   <= raw_v_d;
    end
  end

  assign GY       = gy_q;
  assign is_read  = is_read_q;
  assign cal_done = (state_q == RUN);
  assign offset   = offset_q;

endmodule

// File: doc/gy_offset_cal.md
GY_OFFSET_CAL -- requirements
Module: gy_offset_cal

Interface
REQ-001 SHALL have parameter N_LOG2, 8, log2 of the number of calibration samples (256).
REQ-002 SHALL have parameter DEADBAND, 4, corrected magnitudes strictly below this are forced to 0.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port byte_in  input  8  one gyro Y register byte from the I2C reader.
REQ-006 SHALL have port byte_valid  input  1  byte_in is valid this cycle (one-cycle strobe).
REQ-007 SHALL have port byte_first  input  1  qualifies byte_valid: 1 = high byte (GYRO_YOUT_H), 0 = low byte.
REQ-008 SHALL have port recal  input  1  one-cycle pulse that restarts offset calibration.
REQ-009 SHALL have port GY  output  16  signed, offset-corrected, saturated, deadbanded rate sample for the float conversion stage.
REQ-010 SHALL have port is_read  output  1  one-cycle pulse: GY updated this cycle.
REQ-011 SHALL have port cal_done  output  1  high while in RUN.
REQ-012 SHALL have port offset  output  16  signed offset currently applied.

Function
REQ-013 SHALL assemble a sample: a high byte is held in a pending register; the next low byte completes raw = {hi, lo}, two's complement.
REQ-014 SHALL discard a low byte with no pending high byte; a second high byte SHALL replace the pending one.
REQ-015 SHALL clear the pending flag when a sample completes and on entry to CAL.
REQ-016 SHALL implement states CAL, LATCH, RUN; reset and recal enter CAL.
REQ-017 In CAL SHALL add each completed raw, sign-extended, into a 24-bit signed accumulator and count samples; the 2^N_LOG2-th sample SHALL move the FSM to LATCH.
REQ-018 In LATCH (exactly one cycle) SHALL set offset = accumulator arithmetically shifted right by N_LOG2 (floor), then enter RUN.
REQ-019 SHALL NOT pulse is_read in CAL or LATCH; GY SHALL hold its last value.
REQ-020 In RUN SHALL compute diff = raw - offset at 17 bits and saturate it to [-32768, 32767].
REQ-021 SHALL output 0 when |diff| < DEADBAND, else the saturated diff.
REQ-022 Latency: if the low byte completes a sample in cycle t, GY SHALL update and is_read SHALL be high in cycle t+2 (register raw at t+1; subtract/saturate/deadband registered at t+2).
REQ-023 SHALL accept back-to-back samples every 2 cycles (hi, lo, hi, lo) without loss; the pipeline SHALL not stall.
REQ-024 recal SHALL take priority over byte_valid in the same cycle; that byte SHALL be discarded.
REQ-025 recal in any state SHALL clear the accumulator, count and pending flag, deassert cal_done, and keep offset and GY until the next LATCH; an in-flight pipeline sample SHALL be dropped (no is_read).
REQ-026 The accumulator SHALL NOT overflow: 256 x 16-bit signed fits in 24 bits.

Reset
REQ-027 On rst SHALL set GY=0, is_read=0, cal_done=0, offset=0, accumulator=0, count=0, pending=0, state=CAL.
REQ-028 rst SHALL override recal and byte_valid in the same cycle.

Structure
REQ-029 SHALL place state encoding (CAL, LATCH, RUN), default N_LOG2, DEADBAND and the 24-bit accumulator width in the shared gyro package.
REQ-030 SHALL use one sub-module, gy_byte_assembler, for REQ-013..015 (outputs raw[15:0], raw_valid pulse); the rest of the logic is inline.

Verification
REQ-031 Reset, then 256 samples of 0x0064 (hi 0x00, lo 0x64) -> no is_read; LATCH -> offset=0x0064, cal_done=1.
REQ-032 After REQ-031, sample 0x01F4 -> is_read two cycles after the low byte, GY=0x0190 (400); sample 0x0066 -> GY=0 (deadband).
REQ-033 Calibrate on 0x8064 (offset -32668), then sample 0x7FFF -> GY=0x7FFF (saturated); calibrate on 0x7F00, then sample 0x8000 -> GY=0x8000.
REQ-034 Lone low byte 0x12, then hi 0x01, hi 0x02, lo 0x03 -> exactly one sample, raw=0x0203.
REQ-035 In RUN, recal in the same cycle as a low byte -> that sample dropped, no is_read, cal_done=0; 256 samples of 0xFFFE -> offset=0xFFFE.
REQ-036 Back-to-back hi/lo stream of 10 samples in RUN -> 10 is_read pulses, 2 cycles apart, values in order.
